// File: rtl/motor_ctrl_pkg.sv
// Shared types and default sizes for the motor axis control blocks.
package motor_ctrl_pkg;

  localparam int POS_W            = 32;
  localparam int GAIN_W           = 16;
  localparam int DEFAULT_TICK_DIV = 15000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MOVE   = 3'd1,
    SETTLE = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } state_t;

endpackage

// File: rtl/ctrl_tick_gen.sv
// Free-running divider producing the one-cycle PID control-tick pulse.
module ctrl_tick_gen #(
  parameter int TICK_DIV = 15000
) (
  input  logic clk_150MHz,
  input  logic reset_n,
  output logic ctrl_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic             at_end;

  assign at_end    = (cnt_reg == CNT_W'(TICK_DIV - 1));
  assign ctrl_tick = at_end;

  always_ff @(posedge clk_150MHz or negedge reset_n) begin
    if (!reset_n)    cnt_reg <= '0;
    else if (at_end) cnt_reg <= '0;
    else             cnt_reg <= cnt_reg + 1'b1;
  end

endmodule

// File: rtl/pos_move_sequencer.sv
// Point-to-point move sequencer: ramps the PID setpoint, waits for settle,
// trips on following error, and applies gain updates on control ticks.
module pos_move_sequencer #(
  parameter int POS_W        = motor_ctrl_pkg::POS_W,
  parameter int GAIN_W       = motor_ctrl_pkg::GAIN_W,
  parameter int STEP_W       = 16,
  parameter int TICK_DIV     = motor_ctrl_pkg::DEFAULT_TICK_DIV,
  parameter int SETTLE_TICKS = 100
) (
  input  logic              clk_150MHz,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [POS_W-1:0]  cmd_target,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic              cmd_abort,
  input  logic              fault_clr,
  input  logic [15:0]       tol,
  input  logic [POS_W-1:0]  max_follow_err,
  input  logic [POS_W-1:0]  actual_pos,
  input  logic              gains_load,
  input  logic [GAIN_W-1:0] kp_in,
  input  logic [GAIN_W-1:0] ki_in,
  input  logic [GAIN_W-1:0] kd_in,
  output logic [GAIN_W-1:0] kp_out,
  output logic [GAIN_W-1:0] ki_out,
  output logic [GAIN_W-1:0] kd_out,
  output logic [POS_W-1:0]  desired_pos,
  output logic              pid_enable,
  output logic              ctrl_tick,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [2:0]        state_dbg
);
  import motor_ctrl_pkg::*;

  localparam int SC_W = $clog2(SETTLE_TICKS + 1);

  state_t            state_reg, state_next;
  logic [POS_W-1:0]  desired_reg, desired_next;
  logic [POS_W-1:0]  target_reg, target_next;
  logic [STEP_W-1:0] step_reg, step_next;
  logic [SC_W-1:0]   settle_cnt_reg, settle_cnt_next;
  logic              pid_en_reg, pid_en_next;
  logic              fault_reg, fault_next;
  logic [GAIN_W-1:0] kp_sh_reg, ki_sh_reg, kd_sh_reg;
  logic              pending_reg;

  // All differences are formed one bit wider so they cannot wrap.
  logic [POS_W:0] desired_ext, target_ext, actual_ext, step_ext;
  logic [POS_W:0] ramp_diff, follow_diff, settle_diff;
  logic [POS_W:0] ramp_mag, follow_mag, settle_mag, ramp_sum;
  logic [SC_W-1:0] settle_inc;
  logic           follow_trip, in_tol;

  function automatic logic [POS_W:0] mag(input logic [POS_W:0] v);
    return v[POS_W] ? (~v + 1'b1) : v;
  endfunction

  ctrl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_150MHz (clk_150MHz),
    .reset_n    (reset_n),
    .ctrl_tick  (ctrl_tick)
  );

  assign desired_ext = {desired_reg[POS_W-1], desired_reg};
  assign target_ext  = {target_reg[POS_W-1], target_reg};
  assign actual_ext  = {actual_pos[POS_W-1], actual_pos};
  assign step_ext    = {{(POS_W + 1 - STEP_W){1'b0}}, step_reg};
  assign ramp_diff   = target_ext - desired_ext;
  assign follow_diff = desired_ext - actual_ext;
  assign settle_diff = target_ext - actual_ext;
  assign ramp_mag    = mag(ramp_diff);
  assign follow_mag  = mag(follow_diff);
  assign settle_mag  = mag(settle_diff);
  assign ramp_sum    = ramp_diff[POS_W] ? (desired_ext - step_ext) : (desired_ext + step_ext);
  assign follow_trip = follow_mag > {1'b0, max_follow_err};
  assign in_tol      = settle_mag <= {{(POS_W + 1 - 16){1'b0}}, tol};
  assign settle_inc  = settle_cnt_reg + 1'b1;

  always_comb begin
    state_next      = state_reg;
    desired_next    = desired_reg;
    target_next     = target_reg;
    step_next       = step_reg;
    settle_cnt_next = settle_cnt_reg;
    pid_en_next     = pid_en_reg;
    fault_next      = fault_reg;
    unique case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          target_next = cmd_target;
          step_next   = (cmd_step == '0) ? STEP_W'(1) : cmd_step;
          state_next  = MOVE;
          if (!pid_en_reg) begin
            desired_next = actual_pos;
            pid_en_next  = 1'b1;
          end
        end
      end
      MOVE, SETTLE: begin
        if (cmd_abort) begin
          state_next = IDLE;
        end else if (ctrl_tick) begin
          if (follow_trip) begin
            state_next  = FAULT;
            fault_next  = 1'b1;
            pid_en_next = 1'b0;
          end else if (state_reg == MOVE) begin
            if (ramp_mag <= step_ext) begin
              desired_next    = target_reg;
              settle_cnt_next = '0;
              state_next      = SETTLE;
            end else begin
              desired_next = ramp_sum[POS_W-1:0];
            end
          end else if (in_tol) begin
            settle_cnt_next = settle_inc;
            if (settle_inc == SC_W'(SETTLE_TICKS)) state_next = DONE;
          end else begin
            settle_cnt_next = '0;
          end
        end
      end
      DONE: state_next = IDLE;
      FAULT: begin
        if (fault_clr) begin
          desired_next = actual_pos;
          fault_next   = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_150MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      desired_reg    <= '0;
      target_reg     <= '0;
      step_reg       <= '0;
      settle_cnt_reg <= '0;
      pid_en_reg     <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      desired_reg    <= desired_next;
      target_reg     <= target_next;
      step_reg       <= step_next;
      settle_cnt_reg <= settle_cnt_next;
      pid_en_reg     <= pid_en_next;
      fault_reg      <= fault_next;
    end
  end

  // A load in a tick cycle lands in the shadow after that tick has applied.
  always_ff @(posedge clk_150MHz or negedge reset_n) begin
    if (!reset_n) begin
      kp_sh_reg   <= '0;
      ki_sh_reg   <= '0;
      kd_sh_reg   <= '0;
      kp_out      <= '0;
      ki_out      <= '0;
      kd_out      <= '0;
      pending_reg <= 1'b0;
    end else begin
      if (ctrl_tick && pending_reg) begin
        kp_out      <= kp_sh_reg;
        ki_out      <= ki_sh_reg;
        kd_out      <= kd_sh_reg;
        pending_reg <= 1'b0;
      end
      if (gains_load) begin
        kp_sh_reg   <= kp_in;
        ki_sh_reg   <= ki_in;
        kd_sh_reg   <= kd_in;
        pending_reg <= 1'b1;
      end
    end
  end

  assign cmd_ready   = (state_reg == IDLE);
  assign busy        = (state_reg == MOVE) || (state_reg == SETTLE);
  assign done        = (state_reg == DONE);
  assign fault       = fault_reg;
  assign pid_enable  = pid_en_reg;
  assign desired_pos = desired_reg;
  assign state_dbg   = state_reg;

endmodule

// File: doc/pos_move_sequencer.md
Name: pos_move_sequencer

Overview:
Sequences the position PID loop for one motor axis. Accepts point-to-point move commands via a valid/ready handshake and ramps the PID setpoint (desired_pos) toward the target at a bounded step per control tick. It then waits for the axis to settle, and trips a sticky fault on excessive following error. It also owns the PID control-tick timebase and applies gain updates only on tick boundaries. Sits between the AXI register block and the motor PID/encoder/PWM core.

Parameters:
POS_W, 32, signed position width (desired/actual/target)
GAIN_W, 16, Kp/Ki/Kd width
STEP_W, 16, per-tick step width
TICK_DIV, 15000, clk_150MHz cycles per control tick (10 kHz)
SETTLE_TICKS, 100, consecutive in-tolerance ticks required for done

Ports:
clk_150MHz  in  1  clock
reset_n  in  1  reset
cmd_valid  in  1  move command valid
cmd_ready  out  1  command accepted when valid&&ready
cmd_target  in  POS_W  signed target position
cmd_step  in  STEP_W  unsigned max setpoint change per tick; 0 treated as 1
cmd_abort  in  1  pulse, stop current move
fault_clr  in  1  pulse, clear fault
tol  in  16  unsigned settle tolerance, counts
max_follow_err  in  POS_W  unsigned following-error limit
actual_pos  in  POS_W  signed encoder position
gains_load  in  1  pulse, capture kp_in/ki_in/kd_in
kp_in, ki_in, kd_in  in  GAIN_W each  requested gains
kp_out, ki_out, kd_out  out  GAIN_W each  gains applied to PID
desired_pos  out  POS_W  signed PID setpoint
pid_enable  out  1  PID/PWM enable
ctrl_tick  out  1  one-cycle control-tick pulse
busy  out  1  state is MOVE or SETTLE
done  out  1  one-cycle pulse, move complete
fault  out  1  sticky following-error fault
state_dbg  out  3  encoded state, for LED/debug

Behaviour:
- Reset is asynchronous and active-low on reset_n; the block is clocked on clk_150MHz.
- Reset values: desired_pos=0, gains=0, pid_enable=0, ctrl_tick=0, done=0, fault=0, busy=0, state=IDLE, tick counter=0, settle count=0, gain-pending=0.
- Tick: free-running counter 0..TICK_DIV-1. ctrl_tick=1 for one cycle when the counter equals TICK_DIV-1, then the counter wraps to 0. Not gated by state.
- cmd_ready = (state==IDLE); combinational.
- States: IDLE, MOVE, SETTLE, DONE, FAULT.
- IDLE:
  - On cmd_valid&&cmd_ready: latch target and step, go to MOVE.
  - If pid_enable was 0, load desired_pos<=actual_pos and set pid_enable=1 in the same cycle (bumpless start).
- MOVE, on ctrl_tick:
  - diff = target - desired_pos, computed in POS_W+1 signed.
  - If |diff| <= step: desired_pos<=target, settle count<=0, go to SETTLE.
  - Else: desired_pos += sign(diff)*step.
  - desired_pos never overshoots the target and never wraps.
- SETTLE, on ctrl_tick:
  - If |target - actual_pos| <= tol: count++; otherwise count<=0.
  - When count reaches SETTLE_TICKS, go to DONE.
- DONE: done=1 for one cycle, then IDLE. pid_enable stays 1 to hold position.
- Following error:
  - In MOVE/SETTLE, on each ctrl_tick, evaluate |desired_pos - actual_pos| (POS_W+1 bits), using desired_pos before that tick's update.
  - If it exceeds max_follow_err, go to FAULT. This takes precedence over the ramp and settle updates.
- FAULT:
  - fault=1, pid_enable=0, desired_pos frozen, cmd_ready=0.
  - fault_clr: desired_pos<=actual_pos, fault<=0, go to IDLE (pid_enable stays 0 until the next command).
- cmd_abort in MOVE/SETTLE: go to IDLE the next cycle with desired_pos frozen, no done pulse, pid_enable kept. Abort beats a tick in the same cycle. Abort is ignored in IDLE/DONE/FAULT.
- Gains:
  - gains_load captures kp_in/ki_in/kd_in into shadow registers and sets pending.
  - On the next ctrl_tick after capture, outputs <= shadow and pending<=0.
  - If gains_load coincides with ctrl_tick, apply at the following tick.
  - A repeated load before the tick overwrites the shadow.
  - Gains apply in every state.
- Reset mid-move returns everything to reset values immediately.

Decomposition:
- Shared package motor_ctrl_pkg: state enum (IDLE=0, MOVE=1, SETTLE=2, DONE=3, FAULT=4), POS_W, GAIN_W, DEFAULT_TICK_DIV.
- Sub-module ctrl_tick_gen: divider counter producing ctrl_tick. The FSM, ramp and gain shadow stay in the top.

Test Plan:
All scenarios use TICK_DIV=10 and SETTLE_TICKS=4.
- Ramp and settle: actual_pos tracks desired_pos, target 1000, step 100, tol 5 -> desired_pos goes 100,200,…,1000 on ticks 1–10; done pulses after 4 more ticks; pid_enable stays 1.
- Negative move with clamp: from 0, target -550, step 200 -> desired_pos -200, -400, -550; no overshoot; state goes SETTLE.
- Following-error fault: actual_pos stuck at 0, max_follow_err 250, target 1000, step 100 -> fault on the tick where pre-update desired_pos=300; pid_enable=0; cmd_ready=0. fault_clr -> IDLE with desired_pos=0.
- Abort with simultaneous tick: cmd_abort asserted in the ctrl_tick cycle at desired_pos=300 -> IDLE, desired_pos stays 300, no done.
- Gains: gains_load with kp_in=0x0123 mid-interval -> kp_out changes exactly on the next ctrl_tick. Load on a tick cycle -> change one tick later.
- Reset mid-move: reset_n low during MOVE -> all outputs at reset values asynchronously; the first command after release performs a bumpless load from actual_pos.
